// File: rtl/sha1_wsched.sv
`default_nettype none
// ============================================================================
// Module   : sha1_wsched
// Brief    : SHA-1 message-schedule generator; 16-word circular buffer that
//            emits W[0..NROUNDS-1] one word per accepted `next` strobe.
// Revision : 1.0 - initial release
// ============================================================================
module sha1_wsched #(
  parameter int NROUNDS = 80
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] din,
  input  logic        next,
  output logic [31:0] w,
  output logic [6:0]  t,
  output logic [1:0]  grp,
  output logic        valid,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] c_LAST_T = 7'(NROUNDS - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [31:0] r_buf [16];
  logic [3:0]  r_loadCnt;
  logic [6:0]  r_t;

  logic        w_loadStart;
  logic        w_loadWord;
  logic        w_accept;
  logic        w_lastWord;
  logic        w_computed;
  logic [3:0]  w_idx;
  logic [3:0]  w_idxM3;
  logic [3:0]  w_idxM8;
  logic [3:0]  w_idxM14;
  logic [31:0] w_xor;
  logic [31:0] w_wNew;

  assign w_loadStart = ((r_state == IDLE) || (r_state == DONE)) && load;
  assign w_loadWord  = (r_state == LOAD) && load;
  assign w_accept    = (r_state == RUN) && next;
  assign w_lastWord  = (r_t == c_LAST_T);
  assign w_computed  = (r_t >= 7'd16);

  // Mod-16 indexing falls out of 4-bit wraparound subtraction.
  assign w_idx    = r_t[3:0];
  assign w_idxM3  = w_idx - 4'd3;
  assign w_idxM8  = w_idx - 4'd8;
  assign w_idxM14 = w_idx - 4'd14;
  assign w_xor    = r_buf[w_idxM3] ^ r_buf[w_idxM8] ^ r_buf[w_idxM14] ^ r_buf[w_idx];
  assign w_wNew   = {w_xor[30:0], w_xor[31]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (load) begin
          w_stateNext = LOAD;
        end
      end
      LOAD: begin
        if (load && (r_loadCnt == 4'd15)) begin
          w_stateNext = RUN;
        end
      end
      RUN: begin
        if (next && w_lastWord) begin
          w_stateNext = DONE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_buf[i] <= '0;
      end
      r_loadCnt <= '0;
      r_t       <= '0;
    end else begin
      if (w_loadStart) begin
        r_buf[0]  <= din;
        r_loadCnt <= 4'd1;
        r_t       <= '0;
      end else if (w_loadWord) begin
        r_buf[r_loadCnt] <= din;
        r_loadCnt        <= r_loadCnt + 4'd1;
        r_t              <= '0;
      end else if (w_accept) begin
        // The slot being overwritten held W[t-16], which no later word needs.
        if (w_computed) begin
          r_buf[w_idx] <= w_wNew;
        end
        r_t <= w_lastWord ? 7'd0 : (r_t + 7'd1);
      end
    end
  end

  assign valid = (r_state == RUN);
  assign done  = (r_state == DONE);
  assign t     = valid ? r_t : 7'd0;

  always_comb begin
    w = 32'd0;
    if (valid) begin
      w = w_computed ? w_wNew : r_buf[w_idx];
    end
  end

  always_comb begin
    grp = 2'd3;
    if (t < 7'd20) begin
      grp = 2'd0;
    end else if (t < 7'd40) begin
      grp = 2'd1;
    end else if (t < 7'd60) begin
      grp = 2'd2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha1_wsched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha1_wsched
// Brief    : Scoreboard bench for sha1_wsched against an array-based SHA-1
//            schedule model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha1_wsched;

  logic        clk;
  logic        reset;
  logic        load;
  logic [31:0] din;
  logic        next;
  logic [31:0] w;
  logic [6:0]  t;
  logic [1:0]  grp;
  logic        valid;
  logic        done;

  int nVec = 0;
  int nErr = 0;

  typedef struct {
    int          t;
    logic [31:0] w;
    logic [1:0]  grp;
  } exp_t;

  exp_t expQ[$];
  exp_t eMon;

  sha1_wsched #(.NROUNDS(80)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .din   (din),
    .next  (next),
    .w     (w),
    .t     (t),
    .grp   (grp),
    .valid (valid),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: textbook SHA-1 expansion over a full 80-entry array.
  function automatic void pushBlock(input bit [31:0] m[16]);
    bit [31:0] W[80];
    bit [31:0] x;
    exp_t      e;
    for (int i = 0; i < 80; i++) begin
      if (i < 16) begin
        W[i] = m[i];
      end else begin
        x    = W[i-3] ^ W[i-8] ^ W[i-14] ^ W[i-16];
        W[i] = {x[30:0], x[31]};
      end
      e.t   = i;
      e.w   = W[i];
      e.grp = (i >= 60) ? 2'd3 : 2'(i / 20);
      expQ.push_back(e);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && valid) begin
      nVec++;
      if (expQ.size() == 0) begin
        nErr++;
        $display("FAIL unexpected_word: got t=%0d w=%h, required no valid output", t, w);
      end else begin
        eMon = expQ[0];
        if (w !== eMon.w || t !== 7'(eMon.t) || grp !== eMon.grp) begin
          nErr++;
          $display("FAIL sched_word: got t=%0d w=%h grp=%0d, required t=%0d w=%h grp=%0d",
                   t, w, grp, eMon.t, eMon.w, eMon.grp);
        end
        if (next) void'(expQ.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic loadBlock(input bit [31:0] m[16], input bit b2b);
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = (b2b && i == 0) ? 0 : int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        load = 1'b0;
        next = 1'($urandom_range(0, 1));
        din  = $urandom;
        @(posedge clk); #1;
      end
      load = 1'b1;
      din  = m[i];
      next = (b2b && i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (i == 15) pushBlock(m);
      @(posedge clk); #1;
      if (b2b && i == 0) check("done_clears", {31'd0, done}, 32'd0);
    end
    load = 1'b0;
    next = 1'b0;
    check("valid_after_load", {31'd0, valid}, 32'd1);
  endtask

  task automatic runWords(input int n, input bit randLoad);
    for (int k = 0; k < n; k++) begin
      next = 1'b1;
      load = randLoad ? 1'($urandom_range(0, 1)) : 1'b0;
      din  = $urandom;
      @(posedge clk); #1;
    end
    next = 1'b0;
    load = 1'b0;
  endtask

  task automatic checkDone();
    check("done_set", {31'd0, done}, 32'd1);
    check("valid_drop", {31'd0, valid}, 32'd0);
    check("queue_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    bit [31:0] blk[16];

    reset = 1'b1;
    load  = 1'b0;
    next  = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_t", {25'd0, t}, 32'd0);
    check("rst_w", w, 32'd0);
    check("rst_grp", {30'd0, grp}, 32'd0);

    // "abc" padded block, with a 5-cycle stall at t=16
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    loadBlock(blk, 1'b0);
    runWords(16, 1'b1);
    for (int s = 0; s < 5; s++) begin
      next = 1'b0;
      load = 1'($urandom_range(0, 1));
      din  = $urandom;
      check("stall_w", w, 32'hC2C4C700);
      check("stall_t", {25'd0, t}, 32'd16);
      @(posedge clk); #1;
    end
    load = 1'b0;
    runWords(64, 1'b1);
    checkDone();

    // Random block started in the done cycle with load and next together
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    loadBlock(blk, 1'b1);
    runWords(80, 1'b1);
    checkDone();

    // Abort mid-run at t=37
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    loadBlock(blk, 1'b0);
    runWords(37, 1'b1);
    check("pre_abort_t", {25'd0, t}, 32'd37);
    reset = 1'b1;
    #1;
    expQ.delete();
    check("abort_valid", {31'd0, valid}, 32'd0);
    check("abort_t", {25'd0, t}, 32'd0);
    check("abort_w", w, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fresh block after reset
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    loadBlock(blk, 1'b0);
    runWords(80, 1'b0);
    checkDone();

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sha1_wsched.md
# sha1_wsched

SHA-1 message-schedule generator that sits directly upstream of the round-operation stages (the `op0`–`op3` round blocks, whose `w` input it drives). It accepts one 512-bit message block as sixteen 32-bit words, stores them in a 16-entry circular buffer and presents the expanded schedule W[0..79] one word at a time. The round controller advances it with the same `next` strobe it gives the round stages. It also emits the round-group select so downstream logic can choose the round function and constant.

## Interface
- `NROUNDS`, default 80: number of schedule words produced per block. It must be ≥16; the last index is NROUNDS-1.
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
- `load`, input, 1: `din` holds the next message word (word 0 first, big-endian word order).
- `din`, input, 32: message word.
- `next`, input, 1: advance to the next schedule word. Acts only while `valid`=1.
- `w`, output, 32: current schedule word W[t].
- `t`, output, 7: current round index, 0..NROUNDS-1.
- `grp`, output, 2: round group; 0 for t 0–19, 1 for 20–39, 2 for 40–59, 3 for 60–79.
- `valid`, output, 1: `w`, `t` and `grp` are meaningful.
- `done`, output, 1: all NROUNDS words consumed. Holds until a new load begins.

## Operation
- **States.**
  - IDLE: entered on reset.
  - LOAD: 1–15 words received.
  - RUN: schedule being produced.
  - DONE: all words consumed.
- **IDLE / DONE with `load`=1.**
  - `din` is written to buf[0] and the load count becomes 1.
  - State moves to LOAD; `done` clears.
- **LOAD with `load`=1.**
  - `din` is written to buf[count] and the count increments.
  - When the 16th word is written, the state moves to RUN with t=0.
- **LOAD with `load`=0.** Nothing happens; there is no timeout.
- **RUN, computed word.** For t≥16, wnew = rotl1(buf[(t-3)&15] ^ buf[(t-8)&15] ^ buf[(t-14)&15] ^ buf[t&15]), using mod-16 indexing on the 4 low bits.
- **RUN, output `w`.**
  - t<16: `w` = buf[t&15].
  - t≥16: `w` = wnew.
  - `w` is combinational from registered state; there is no extra register stage.
- **RUN with `next`=1.**
  - If t≥16, wnew is written into buf[t&15].
  - If t<NROUNDS-1, t increments.
  - If t=NROUNDS-1, the state moves to DONE: `valid` drops and `done` rises.
- **Ignored inputs.**
  - `load` is ignored in RUN; a word arriving then is dropped.
  - `next` is ignored in IDLE, LOAD and DONE.
- **Simultaneous `load` and `next`.** In RUN, `next` wins and `load` is ignored. In DONE, `load` wins.
- **`grp`.** Decoded from `t`; it saturates at 3 for any t≥60.
- **Outputs outside RUN.** `w` = 0 and `t` = 0.

## Timing
- **Reset values.** `w`=0, `t`=0, `grp`=0, `valid`=0, `done`=0, state IDLE. The buffer and load count clear to 0. Reset asserted mid-LOAD or mid-RUN aborts immediately, with no partial output.
- **Load to first word.** The edge that captures word 15 makes `valid`=1 with t=0 and `w`=W[0] in the following cycle. Minimum load-to-first-word latency is 16 cycles.
- **Throughput.** One schedule word per cycle when `next` is held high. NROUNDS `next` pulses complete a block.
- **`done`.** Rises on the clock edge that accepts `next` at t=NROUNDS-1.
- **Back-to-back blocks.** A new block may begin loading in the cycle `done` is high.
- **Downstream alignment.** The round stage samples `w` on the same edge that `next` advances `t`, so W[t] reaches round t with zero skew.

## Test plan
- **Reset values.** Assert `reset` mid-RUN at t=37 → next cycle `valid`=0, `t`=0, `w`=0, `done`=0. A fresh 16-word load then restarts at t=0.
- **"abc" block.** Load W0=0x61626380, W1..W14=0, W15=0x00000018 → at t=0 `w`=0x61626380, t=15 0x00000018, t=16 0xC2C4C700, t=17 0x00000000, t=18 0x00000030.
- **Full 80-word expansion.** Random block with continuous `next` → all 80 words match a reference model. `grp` changes exactly at t=20, 40, 60. `done` is set after 80 pulses.
- **Stalled `next`.** Hold `next` low for 5 cycles at t=16 → `w` stays 0xC2C4C700 and `t` stays 16. There is no double write into buf[0]: t=17 and later still match the model.
- **Ignored inputs.** `load` pulses during RUN and `next` pulses during LOAD → no state change; the schedule still matches the model.
- **Back-to-back blocks.** Start loading block 2 in the `done` cycle, driving `load` and `next` high together → `done` clears. Block 2's W[0..79] is correct and independent of block 1.
